// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial subtractor, D = A - B computed LSB first, one bit per clock,
// through a single full-subtractor cell and a borrow flip-flop.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (A minuend, B subtrahend)
//   out_valid/out_ready result handshake
//   D   difference A-B mod 2^WIDTH
//   BO  borrow out (unsigned A < B)
//   Z   D == 0
//   V   signed overflow
module sub8_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             Z,
  output logic             V
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, res, res_next;
  logic [CW-1:0]    cnt;
  logic             borrow, a_msb, b_msb;
  logic             bit_a, bit_b, diff, bout;
  logic             take, last;

  // Next-state logic and the full-subtractor cell
  always_comb begin
    state_next = state;
    take       = 1'b0;
    last       = 1'b0;
    bit_a      = sa[0];
    bit_b      = sb[0];
    diff       = bit_a ^ bit_b ^ borrow;
    bout       = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    res_next   = {diff, res[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          take       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand shift registers, borrow FF, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      D      <= '0;
      BO     <= 1'b0;
      Z      <= 1'b0;
      V      <= 1'b0;
    end else if (take) begin
      sa     <= A;
      sb     <= B;
      borrow <= 1'b0;
      cnt    <= '0;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == SHIFT) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      borrow <= bout;
      cnt    <= cnt + CW'(1);
      res    <= res_next;
      if (last) begin
        D  <= res_next;
        BO <= bout;
        Z  <= (res_next == '0);
        // Overflow only when operand signs differ and the result sign differs from A
        V  <= (a_msb ^ b_msb) & (a_msb ^ res_next[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_sub8_serial.sv
// tb_sub8_serial: directed and random checks of sub8_serial against a reference A-B model.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, d;
  logic       bo, z, v;
  int         n_cmp = 0;
  int         n_err = 0;

  sub8_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .D(d), .BO(bo), .Z(z), .V(v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation; noise drives ignored in_valid traffic while busy,
  // rnd_rdy toggles out_ready randomly before the result appears.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input int stall,
                       input bit noise, input bit rnd_rdy);
    logic [7:0] ed;
    logic       ebo, ez, ev;
    int         lat;
    ed  = oa - ob;
    ebo = (oa < ob);
    ez  = (ed == 8'h00);
    ev  = (oa[7] ^ ob[7]) & (oa[7] ^ ed[7]);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = oa; b = ob;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin in_valid = 1'b1; a = 8'h11; b = 8'h00; end
      if (rnd_rdy) out_ready = 1'($urandom_range(1, 0));
      if (noise) check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd8);
    check("D", 32'(d), 32'(ed));
    check("BO", 32'(bo), 32'(ebo));
    check("Z", 32'(z), 32'(ez));
    check("V", 32'(v), 32'(ev));
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_D", 32'({bo, z, v, d}), 32'({ebo, ez, ev, ed}));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    check("retain", 32'({bo, z, v, d}), 32'({ebo, ez, ev, ed}));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outs", 32'({bo, z, v, d}), 32'd0);

    do_op(8'h05, 8'h03, 0, 1'b0, 1'b0);
    do_op(8'h03, 8'h05, 0, 1'b0, 1'b0);
    do_op(8'h00, 8'hFF, 1, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 0, 1'b0, 1'b0);
    do_op(8'h7F, 8'hFF, 2, 1'b0, 1'b0);
    do_op(8'h5A, 8'h5A, 5, 1'b1, 1'b0);
    do_op(8'h22, 8'h11, 0, 1'b0, 1'b0);

    // Abort mid-SHIFT
    in_valid = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_D", 32'({bo, z, v, d}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);
    do_op(8'h10, 8'h01, 0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(3, 0)), 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
